// File: rtl/reset_sequencer.sv
`default_nettype none
// reset_sequencer: PLL reset / SoC reset bring-up with lock supervision,
// debounced button restart and a fault latch after repeated lock timeouts.
module reset_sequencer #(
  parameter int PLL_RESET_CYCLES = 4,
  parameter int LOCK_TIMEOUT     = 100,
  parameter int HOLD_CYCLES      = 16,
  parameter int DEBOUNCE_CYCLES  = 8,
  parameter int MAX_RETRIES      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       pll_locked,
  output logic       pll_reset,
  output logic       soc_reset,
  output logic       ready,
  output logic       fault,
  output logic [7:0] retry_count
);

  localparam int MAX_A   = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (HOLD_CYCLES > DEBOUNCE_CYCLES) ? HOLD_CYCLES : DEBOUNCE_CYCLES;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_MAX = (MAX_C > MAX_RETRIES) ? MAX_C : MAX_RETRIES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] PR_LAST   = CW'(PLL_RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DB_FULL   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RETRY_LIM = CW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [CW-1:0] consec, consec_next;
  logic [7:0]    retry_next;
  logic          pll_reset_next, soc_reset_next, ready_next, fault_next;

  logic          btn_meta, btn_s, lock_meta, lock_s;
  logic [CW-1:0] db_cnt;
  logic          db_fired;
  logic          press;

  // Button synchronizer idles high so a reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta  <= 1'b1;
      btn_s     <= 1'b1;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      btn_meta  <= btn_n;
      btn_s     <= btn_meta;
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Counter parks at full scale; db_fired blocks repeat pulses until release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt   <= '0;
      db_fired <= 1'b0;
    end else if (btn_s) begin
      db_cnt   <= '0;
      db_fired <= 1'b0;
    end else begin
      if (db_cnt != DB_FULL) db_cnt <= db_cnt + 1'b1;
      if (press) db_fired <= 1'b1;
    end
  end

  assign press = (db_cnt == DB_FULL) && !db_fired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PLL_RST;
      cnt         <= '0;
      consec      <= '0;
      retry_count <= 8'd0;
      pll_reset   <= 1'b1;
      soc_reset   <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      consec      <= consec_next;
      retry_count <= retry_next;
      pll_reset   <= pll_reset_next;
      soc_reset   <= soc_reset_next;
      ready       <= ready_next;
      fault       <= fault_next;
    end
  end

  always_comb begin
    state_next  = state;
    consec_next = consec;
    retry_next  = retry_count;

    if (press) begin
      state_next = PLL_RST;
      if (state == FAULT) consec_next = '0;
    end else begin
      unique case (state)
        PLL_RST: begin
          if (cnt == PR_LAST) state_next = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_next = HOLD;
          end else if (cnt == TO_LAST) begin
            if (retry_count != 8'hFF) retry_next = retry_count + 8'd1;
            consec_next = consec + 1'b1;
            state_next  = (consec_next == RETRY_LIM) ? FAULT : PLL_RST;
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state_next = PLL_RST;
          end else if (cnt == HOLD_LAST) begin
            state_next  = RUN;
            consec_next = '0;
          end
        end
        RUN: begin
          if (!lock_s) state_next = PLL_RST;
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next = PLL_RST;
        end
      endcase
    end

    // A press re-enters PLL_RST even from PLL_RST, so it restarts the count.
    if (press || (state_next != state) || (state_next == RUN) || (state_next == FAULT))
      cnt_next = '0;
    else
      cnt_next = cnt + 1'b1;

    pll_reset_next = (state_next == PLL_RST);
    soc_reset_next = (state_next != RUN);
    ready_next     = (state_next == RUN);
    fault_next     = (state_next == FAULT);
  end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Power-up and recovery sequencer for the clock/reset front end of the FPGA top level. Runs on the free-running board clock and drives the PLL reset. It holds the mini16 SoC in reset until the PLL has been locked and stable for a programmable time. It restarts the sequence on a debounced push-button press or on loss of lock, and gives up into a fault state after repeated lock timeouts.

## Interface
- `PLL_RESET_CYCLES`, default 4: cycles `pll_reset` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, default 100: cycles to wait for synchronized lock before retrying (≥1).
- `HOLD_CYCLES`, default 16: cycles of stable lock before `soc_reset` is released (≥1).
- `DEBOUNCE_CYCLES`, default 8: consecutive low samples of the button that count as a press (≥1).
- `MAX_RETRIES`, default 3: consecutive lock timeouts that cause entry to FAULT (≥1).
- Counter widths are `$clog2` of the largest cycle parameter plus 1.
- `clk`, input, 1: free-running board clock. This is the only clock.
- `reset`, input, 1: asynchronous, active-high global reset.
- `btn_n`, input, 1: raw active-low push button, asynchronous to `clk`.
- `pll_locked`, input, 1: PLL lock indicator, asynchronous to `clk`.
- `pll_reset`, output, 1: PLL reset, active-high.
- `soc_reset`, output, 1: SoC reset request, active-high. The consumer re-synchronizes it into the PLL clock domain.
- `ready`, output, 1: high while in RUN.
- `fault`, output, 1: high while in FAULT.
- `retry_count`, output, 8: total lock timeouts since `reset`. Saturates at 255.

## Operation
- `btn_n` and `pll_locked` each pass through a 2-flop synchronizer, giving `btn_s` and `lock_s`.
- Debounce:
  - Counter increments while `btn_s`=0 and clears while `btn_s`=1.
  - `press` pulses for one cycle when the counter reaches `DEBOUNCE_CYCLES`.
  - There is no further pulse until `btn_s` returns to 1.
- States: PLL_RST, WAIT_LOCK, HOLD, RUN, FAULT. Cycle counter `cnt` clears on every state entry.
- PLL_RST:
  - `pll_reset`=1, `soc_reset`=1.
  - After `PLL_RESET_CYCLES` cycles in state, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_reset`=0, `soc_reset`=1.
  - `lock_s`=1: go to HOLD.
  - Otherwise, after `LOCK_TIMEOUT` cycles: a timeout. Increment `retry_count` (saturating) and the internal consecutive-retry counter.
  - On timeout, if the consecutive count now equals `MAX_RETRIES`, go to FAULT; else go to PLL_RST.
- HOLD:
  - `soc_reset`=1.
  - `lock_s`=0: go to PLL_RST.
  - After `HOLD_CYCLES` cycles in state with lock held: go to RUN and clear the consecutive-retry counter.
- RUN:
  - `soc_reset`=0, `ready`=1.
  - `lock_s`=0: go to PLL_RST.
- FAULT:
  - `pll_reset`=0, `soc_reset`=1, `fault`=1.
  - Leave only via `press` (to PLL_RST, consecutive counter cleared) or `reset`.
- `press` in any state: go to PLL_RST. This has priority over every other transition in the same cycle.
- Lock loss has priority over HOLD/timeout expiry in the same cycle.

## Timing
- Reset values, asynchronous on `reset`:
  - state=PLL_RST, all counters 0, both synchronizers 0 (`btn_s` resets to 1).
  - `pll_reset`=1, `soc_reset`=1, `ready`=0, `fault`=0, `retry_count`=0.
- Reset asserted mid-operation aborts immediately and asynchronously to these values.
- Outputs are dedicated flops loaded with the decode of the next state. They change on the same edge as the state, with no glitches and no extra latency.
- `pll_reset` is high for exactly `PLL_RESET_CYCLES` cycles after `reset` deasserts, then falls.
- Lock latency: `lock_s` rises 2 edges after `pll_locked`. HOLD is entered on the next edge. `soc_reset` falls `HOLD_CYCLES` edges later, i.e. 3+`HOLD_CYCLES` edges after `pll_locked` rises.
- Lock loss in RUN: `soc_reset`=1 and `pll_reset`=1 appear 3 edges after `pll_locked` falls.
- Button: `press` fires `DEBOUNCE_CYCLES`+2 edges after `btn_n` falls and stays low. PLL_RST outputs appear 1 edge after `press`.

## Test plan
- Nominal bring-up (defaults): release `reset` and raise `pll_locked` at cycle 10.
  - Required: `pll_reset` high cycles 0–3.
  - Required: `soc_reset` falls at cycle 29 and `ready`=1 from then; `retry_count`=0.
- Glitchy lock: `pll_locked` high for 5 cycles during HOLD, then low.
  - Required: return to PLL_RST with `pll_reset`=1 for 4 cycles; `soc_reset` never falls.
- Timeout and fault: `pll_locked` held 0.
  - Required: 3 timeouts of 100 cycles each, `retry_count`=3, `fault`=1, `pll_reset`=0, `soc_reset`=1.
  - Then a clean button press: required exit to PLL_RST, `fault`=0.
- Debounce: `btn_n` bounces low for 5 cycles ×3, then stays low 20 cycles, while in RUN.
  - Required: exactly one restart, `ready` falls 11 cycles after the final fall; no second restart while held low.
- Press and lock loss in the same cycle.
  - Required: PLL_RST entered once, counter at 0, `pll_reset` high exactly 4 cycles.
- Async `reset` pulse mid-HOLD, not aligned to `clk`.
  - Required: all outputs take reset values immediately, the sequence restarts from cycle 0, and `retry_count` clears.
